stream_mux_rr: RTL and testbench

- N-channel, W-bit streaming multiplexer with a valid/ready handshake on every input and on the output. This is the parametrised, clocked successor to the team's combinational 4:1 bit mux.
- Two selection modes:
  - fixed: a software-driven channel select.
  - round-robin: fair arbitration across requesting channels.
- Packet-aware: once a channel wins, it holds the output until its `last` beat.
- Sits between per-channel producers and a single downstream consumer. The output is registered (1-cycle latency).

---
 rtl/stream_mux_rr.sv | 214 +++++++++++++++++++++
 tb/tb_stream_mux_rr.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//
// N-channel, W-bit streaming multiplexer with valid/ready handshakes on every
// input and on the single registered output (one cycle of latency). Selection
// is either fixed (software-driven `sel`) or round-robin across requesting
// channels. Once a channel wins with a non-last beat, it keeps the output
// until its `last` beat has been transferred.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset (synchronous release expected)
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel chosen in fixed mode
//   in_data    channel i occupies bits [i*W +: W]
//   in_valid   per-channel beat valid
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel accept (one-hot or zero)
//   out_data   registered output beat
//   out_valid  output beat valid
//   out_last   end-of-packet flag of the output beat
//   out_ch     source channel of the output beat
//   out_ready  downstream accept
// -----------------------------------------------------------------------------
module stream_mux_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic            out_last,
    output logic [SW-1:0]   out_ch,
    input  logic            out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   lock_ch_reg, lock_ch_next;
    // Mode captured when a packet locks, so a mode change mid-packet cannot
    // alter how that packet's completion updates the round-robin pointer.
    logic            lock_mode_reg, lock_mode_next;
    logic [SW-1:0]   rr_ptr_reg, rr_ptr_next;

    logic [W-1:0]    out_data_reg, out_data_next;
    logic            out_valid_reg, out_valid_next;
    logic            out_last_reg, out_last_next;
    logic [SW-1:0]   out_ch_reg, out_ch_next;

    // ------------------------------------------------------------------
    // Round-robin candidates: slot gi holds channel (rr_ptr + 1 + gi) mod N,
    // so slot 0 is the highest-priority channel this cycle.
    // ------------------------------------------------------------------
    logic [SW-1:0]   rr_idx [N];
    logic [N-1:0]    rr_hit;
    logic            rr_found;
    logic [SW-1:0]   rr_ch;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rr_slot
            logic [SW:0] rr_sum;
            // rr_ptr < N, so the sum is below 2N and one subtraction wraps it.
            assign rr_sum      = {1'b0, rr_ptr_reg} + (SW+1)'(gi + 1);
            assign rr_idx[gi]  = (rr_sum >= (SW+1)'(N)) ? SW'(rr_sum - (SW+1)'(N))
                                                        : SW'(rr_sum);
            assign rr_hit[gi]  = in_valid[rr_idx[gi]];
        end
    endgenerate

    always_comb begin
        rr_found = 1'b0;
        rr_ch    = '0;
        // Walk from lowest priority to highest so the highest-priority hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rr_hit[k]) begin
                rr_found = 1'b1;
                rr_ch    = rr_idx[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic            has_grant;
    logic [SW-1:0]   grant_ch;
    logic            sel_in_range;
    logic            load_ok;
    logic            xfer;
    logic            xfer_last;
    logic [W-1:0]    xfer_data;

    assign sel_in_range = ({1'b0, sel} < (SW+1)'(N));

    always_comb begin
        has_grant = 1'b0;
        grant_ch  = '0;
        if (state_reg == LOCKED) begin
            // The locked channel owns the output even through idle gaps.
            has_grant = 1'b1;
            grant_ch  = lock_ch_reg;
        end else if (mode) begin
            has_grant = rr_found;
            grant_ch  = rr_ch;
        end else begin
            has_grant = sel_in_range && in_valid[sel];
            grant_ch  = sel;
        end
    end

    assign load_ok = !out_valid_reg || out_ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            // rst_n gating keeps every in_ready low while reset is held.
            assign in_ready[gi] = rst_n && has_grant && load_ok && (grant_ch == SW'(gi));
        end
    endgenerate

    assign xfer      = |(in_ready & in_valid);
    assign xfer_last = in_last[grant_ch];
    assign xfer_data = in_data[int'(grant_ch) * W +: W];

    // ------------------------------------------------------------------
    // Next-state and output-register logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        lock_ch_next   = lock_ch_reg;
        lock_mode_next = lock_mode_reg;
        rr_ptr_next    = rr_ptr_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        out_ch_next    = out_ch_reg;

        if (load_ok) begin
            out_valid_next = xfer;
            if (xfer) begin
                out_data_next = xfer_data;
                out_last_next = xfer_last;
                out_ch_next   = grant_ch;
            end
        end

        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    if (xfer_last) begin
                        if (mode) begin
                            rr_ptr_next = grant_ch;
                        end
                    end else begin
                        state_next     = LOCKED;
                        lock_ch_next   = grant_ch;
                        lock_mode_next = mode;
                    end
                end
            end
            LOCKED: begin
                if (xfer && xfer_last) begin
                    state_next = IDLE;
                    if (lock_mode_reg) begin
                        rr_ptr_next = lock_ch_reg;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lock_ch_reg   <= '0;
            lock_mode_reg <= 1'b0;
            // Pointer at the last channel gives channel 0 first priority.
            rr_ptr_reg    <= SW'(N - 1);
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_ch_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            lock_ch_reg   <= lock_ch_next;
            lock_mode_reg <= lock_mode_next;
            rr_ptr_reg    <= rr_ptr_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            out_ch_reg    <= out_ch_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
//
// Directed bench for stream_mux_rr (N=4, W=8). Each scenario task drives its
// own stimulus and compares against hand-computed values. Inputs change 1 ns
// after a rising edge; registered outputs are checked at that point and
// combinational in_ready 1 ns later.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            clk;
    logic            rst_n;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic [SW-1:0]   out_ch;
    logic            out_ready;

    int n_cmp = 0;
    int n_err = 0;

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            $display("[%0t] beat ch=%0d data=%02h last=%0b", $time, out_ch, out_data, out_last);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1;
        in_data = 32'h13_12_11_10; in_valid = 4'b1111; in_last = 4'b1111;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_out_ch got=%0d want=0", out_ch); end
        n_cmp++; if (out_data !== 8'h00 || out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_data got=%02h/%b want=00/0", out_data, out_last); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
        rst_n = 1'b1; #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got=%b want=0001", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin n_err++; $display("FAIL reset_first_beat got=%b/%0d want=1/0", out_valid, out_ch); end
        // Asynchronous assertion mid-cycle with a beat in the output register.
        #2 rst_n = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_async got=%b/%0d/%b want=0/0/0000", out_valid, out_ch, in_ready); end
        tick();
        rst_n = 1'b1; #1;
        // Pointer restored: channel 0 first again, not channel 1.
        n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL reset_ptr_restore got=%b want=0001", in_ready); end
        in_valid = 4'b0000;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle got=%b want=0", out_valid); end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        in_data = 32'h44_A5_22_11; in_valid = 4'b1111; in_last = 4'b1111; #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_in_ready got=%b want=0100", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2 || out_last !== 1'b1) begin
            n_err++; $display("FAIL fixed_beat got=%b/%02h/%0d/%b want=1/a5/2/1", out_valid, out_data, out_ch, out_last); end
        sel = 2'd1; in_valid = 4'b1101; #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL fixed_no_grant got=%b want=0000", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fixed_drain got=%b want=0", out_valid); end
        in_valid = 4'b0000;
    endtask

    task automatic test_rr();
        logic [SW-1:0] exp_ch [5];
        exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd2; exp_ch[3] = 2'd3; exp_ch[4] = 2'd0;
        mode = 1'b1; out_ready = 1'b1;
        in_data = 32'h13_12_11_10; in_valid = 4'b1111; in_last = 4'b1111; #1;
        // Fixed-mode traffic must not have moved the pointer away from 3.
        n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rr_start got=%b want=0001", in_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_ch !== exp_ch[i] || out_data !== (8'h10 + 8'(exp_ch[i]))) begin
                n_err++; $display("FAIL rr_seq%0d got=%b/%0d/%02h want=1/%0d/%02h", i, out_valid, out_ch, out_data, exp_ch[i], 8'h10 + 8'(exp_ch[i])); end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_lock();
        // Pointer is 0, so channel 1 is first in line.
        mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
        in_data = 32'h03_02_B1_00; in_valid = 4'b0111; in_last = 4'b0101; #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL lock_first got=%b want=0010", in_ready); end
        tick();
        n_cmp++; if (out_ch !== 2'd1 || out_data !== 8'hB1 || out_last !== 1'b0) begin
            n_err++; $display("FAIL lock_beat1 got=%0d/%02h/%b want=1/b1/0", out_ch, out_data, out_last); end
        mode = 1'b0; sel = 2'd0; in_data = 32'h03_02_B2_00; #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL lock_hold_fixed got=%b want=0010", in_ready); end
        tick();
        n_cmp++; if (out_ch !== 2'd1 || out_data !== 8'hB2 || out_last !== 1'b0) begin
            n_err++; $display("FAIL lock_beat2 got=%0d/%02h/%b want=1/b2/0", out_ch, out_data, out_last); end
        mode = 1'b1; sel = 2'd3; in_data = 32'h03_02_B3_00; in_last = 4'b0111; #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL lock_hold_rr got=%b want=0010", in_ready); end
        tick();
        n_cmp++; if (out_ch !== 2'd1 || out_data !== 8'hB3 || out_last !== 1'b1) begin
            n_err++; $display("FAIL lock_beat3 got=%0d/%02h/%b want=1/b3/1", out_ch, out_data, out_last); end
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL lock_next_grant got=%b want=0100", in_ready); end
        tick();
        n_cmp++; if (out_ch !== 2'd2 || out_data !== 8'h02) begin n_err++; $display("FAIL lock_next_beat got=%0d/%02h want=2/02", out_ch, out_data); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        // Pointer is 2: channel 3 goes first.
        mode = 1'b1; out_ready = 1'b1;
        in_data = 32'h33_32_31_30; in_valid = 4'b1111; in_last = 4'b1111; #1;
        n_cmp++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL bp_first got=%b want=1000", in_ready); end
        tick();
        out_ready = 1'b0; in_data = 32'h43_42_41_40; #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h33 || out_ch !== 2'd3 || out_last !== 1'b1) begin
                n_err++; $display("FAIL bp_stall%0d got=%b/%b/%02h/%0d/%b want=0000/1/33/3/1", i, in_ready, out_valid, out_data, out_ch, out_last); end
            tick();
        end
        out_ready = 1'b1; #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL bp_release got=%b want=0001", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h40) begin
            n_err++; $display("FAIL bp_no_bubble got=%b/%0d/%02h want=1/0/40", out_valid, out_ch, out_data); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h41) begin
            n_err++; $display("FAIL bp_follow got=%b/%0d/%02h want=1/1/41", out_valid, out_ch, out_data); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_gap_wrap();
        // Pointer is 1; a single-beat ch3 packet moves it to 3.
        mode = 1'b1; out_ready = 1'b1;
        in_data = 32'hC3_00_00_00; in_valid = 4'b1000; in_last = 4'b1000; #1;
        n_cmp++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_setup got=%b want=1000", in_ready); end
        tick();
        in_data = 32'hC4_00_00_00; #1;
        n_cmp++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_grant got=%b want=1000", in_ready); end
        tick();
        n_cmp++; if (out_ch !== 2'd3 || out_data !== 8'hC4) begin n_err++; $display("FAIL wrap_beat got=%0d/%02h want=3/c4", out_ch, out_data); end
        // Pointer 3: channel 0 starts a two-beat packet with a gap between beats.
        in_data = 32'h00_00_00_D0; in_valid = 4'b0001; in_last = 4'b0000; #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL gap_first got=%b want=0001", in_ready); end
        tick();
        n_cmp++; if (out_ch !== 2'd0 || out_data !== 8'hD0 || out_last !== 1'b0) begin
            n_err++; $display("FAIL gap_beat1 got=%0d/%02h/%b want=0/d0/0", out_ch, out_data, out_last); end
        in_valid = 4'b1110; in_last = 4'b1110;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL gap_hold%0d got=%b want=0001", i, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_idle%0d got=%b want=0", i, out_valid); end
        end
        in_data = 32'h00_00_00_D1; in_valid = 4'b0001; in_last = 4'b0001;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hD1 || out_last !== 1'b1) begin
            n_err++; $display("FAIL gap_beat2 got=%b/%0d/%02h/%b want=1/0/d1/1", out_valid, out_ch, out_data, out_last); end
        in_valid = 4'b1110; in_last = 4'b1110; #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL gap_after got=%b want=0010", in_ready); end
        in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr();
        test_lock();
        test_back_to_back();
        test_gap_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
